// File: rtl/div_seq_pkg.sv
// div_seq_pkg
//   Shared definitions for the iterative divider sequencer: FSM state
//   encodings, start/stop levels, iteration count and the sign helpers
//   used around the unsigned core.
package div_seq_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int DIV_W      = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // Magnitude of a possibly-signed operand. 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] abs_if(input logic sgn, input logic [DIV_W-1:0] v);
    return (sgn && v[DIV_W-1]) ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [DIV_W-1:0] neg_if(input logic neg, input logic [DIV_W-1:0] v);
    return neg ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step
//   One restoring shift-subtract iteration (combinational).
//   work      in  65  {partial remainder [64:32], dividend/quotient [31:0]}
//   divisor   in  32  unsigned divisor magnitude
//   work_next out 65  working register after one quotient bit
module div_step
  import div_seq_pkg::*;
(
  input  logic [2*DIV_W:0]  work,
  input  logic [DIV_W-1:0]  divisor,
  output logic [2*DIV_W:0]  work_next
);

  // Trial value is the remainder shifted left with the next dividend bit.
  // work[64] is always zero while running, so including it leaves the
  // result unchanged and gives a clean borrow bit at diff[33].
  logic [DIV_W+1:0] diff;

  assign diff = work[2*DIV_W:DIV_W-1] - {2'b00, divisor};

  always_comb begin
    work_next = {work[2*DIV_W-1:0], 1'b0};
    if (!diff[DIV_W+1]) begin
      work_next = {diff[DIV_W:0], work[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq
//   Iterative DIV/DIVU sequencer for EX. Latches operand magnitudes,
//   runs one quotient bit per cycle through div_step, applies the sign
//   fix-up and holds the pipeline through stallreq until ready.
//   clk, rst         clock, synchronous active-high reset
//   start            EX holds a DIV/DIVU (is_div & ~ready)
//   signed_div       1 = DIV, 0 = DIVU
//   opdata1/opdata2  dividend / divisor
//   annul            abort current operation
//   result_lo/hi     quotient / remainder, registered
//   ready            result valid (DONE state)
//   stallreq         stall request to the pipeline controller
//
//   state    | meaning
//   DIV_IDLE | waiting for start
//   DIV_BUSY | iterating, one quotient bit per cycle
//   DIV_DONE | result valid, waiting for start to drop
module div_seq #(
  parameter int DIV_CYCLES = div_seq_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        ready,
  output logic        stallreq
);
  import div_seq_pkg::*;

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic [64:0] work;
  logic [64:0] work_next;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] abs_op1;
  logic [31:0] abs_op2;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        work_msb_unused;

  assign abs_op1 = abs_if(signed_div, opdata1);
  assign abs_op2 = abs_if(signed_div, opdata2);

  div_step u_div_step (
    .work      (work),
    .divisor   (divisor),
    .work_next (work_next)
  );

  // Results are taken from the final iteration's output so they land
  // in the same edge that enters DONE.
  assign quo = neg_if(neg_q, work_next[31:0]);
  assign rem = neg_if(neg_r, work_next[63:32]);
  // Remainder is always below the divisor, so bit 64 stays zero.
  assign work_msb_unused = work_next[64];

  assign stallreq = (start == DivStart) && (state != DIV_DONE) && !annul;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      work      <= '0;
      divisor   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      ready     <= 1'b0;
    end else if (annul) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start == DivStart) begin
            if (opdata2 != 32'd0) begin
              divisor <= abs_op2;
              neg_q   <= signed_div & (opdata1[31] ^ opdata2[31]);
              neg_r   <= signed_div & opdata1[31];
              work    <= {33'b0, abs_op1};
              cnt     <= '0;
              state   <= DIV_BUSY;
            end else begin
              result_lo <= '0;
              result_hi <= '0;
              ready     <= 1'b1;
              state     <= DIV_DONE;
            end
          end
        end
        DIV_BUSY: begin
          work <= work_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            cnt       <= '0;
            result_lo <= quo;
            result_hi <= rem;
            ready     <= 1'b1;
            state     <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (start == DivStop) begin
            ready <= 1'b0;
            state <= DIV_IDLE;
          end
        end
        default: begin
          ready <= 1'b0;
          state <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq
//   Directed bench for div_seq: hand-computed quotient/remainder vectors,
//   latency and stallreq checks, divide-by-zero, annul, back-to-back and
//   mid-operation reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        ready;
  logic        stallreq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one division the way EX does: start rises after an edge and
  // drops as soon as ready is seen. Latency counts edges from the start
  // cycle to the DONE cycle.
  task automatic run_div(input string tag, input logic sdiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         output int done_cyc);
    int   lat;
    logic stall_ok;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sdiv;
    opdata1    = a;
    opdata2    = b;
    lat        = 0;
    stall_ok   = 1'b1;
    @(negedge clk);
    while (ready !== 1'b1 && lat < 100) begin
      if (stallreq !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    done_cyc = cyc;
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_stall_held"}, 64'(stall_ok), 64'd1);
    check_val({tag, "_stall_done"}, 64'(stallreq), 64'd0);
    check_val({tag, "_lo"}, 64'(result_lo), 64'(exp_lo));
    check_val({tag, "_hi"}, 64'(result_hi), 64'(exp_hi));
    start = 1'b0;
  endtask

  initial begin
    int   c1;
    int   c2;
    logic rdy_seen;

    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_lo", 64'(result_lo), 64'd0);
    check_val("reset_hi", 64'(result_hi), 64'd0);
    check_val("reset_ready", 64'(ready), 64'd0);
    check_val("reset_stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_div("divu_7_2",      1'b0, 32'd7,          32'd2,          33, 32'd3,          32'd1,          c1);
    run_div("div_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  c1);
    run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE,  33, 32'hFFFF_FFFD,  32'd1,          c1);
    run_div("div_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'h8000_0000,  32'd0,          c1);
    run_div("divu_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          33, 32'hFFFF_FFFF,  32'd0,          c1);
    run_div("divu_min_max",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,          32'h8000_0000,  c1);
    run_div("div_by_zero",   1'b1, 32'd5,          32'd0,          1,  32'd0,          32'd0,          c1);

    run_div("b2b_first",     1'b0, 32'd9,          32'd4,          33, 32'd2,          32'd1,          c1);
    run_div("b2b_second",    1'b0, 32'd10,         32'd3,          33, 32'd3,          32'd1,          c2);
    check_val("b2b_gap", 64'(c2 - c1), 64'd34);

    // Annul on the 10th BUSY cycle while start is still high.
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    check_val("annul_stall_drop", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    rdy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) rdy_seen = 1'b1;
    end
    check_val("annul_no_ready", 64'(rdy_seen), 64'd0);
    check_val("annul_keep_lo", 64'(result_lo), 64'd3);
    check_val("annul_keep_hi", 64'(result_hi), 64'd1);
    run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          33, 32'd14,         32'd2,          c1);

    // Reset on the 5th BUSY cycle.
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd1000;
    opdata2    = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_lo", 64'(result_lo), 64'd0);
    check_val("midrst_hi", 64'(result_hi), 64'd0);
    check_val("midrst_ready", 64'(ready), 64'd0);
    check_val("midrst_stall", 64'(stallreq), 64'd0);
    run_div("after_rst",     1'b0, 32'd1000,       32'd3,          33, 32'd333,        32'd1,          c1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-cycle divider sequencer serving the EX stage for DIV/DIVU. It accepts operands from EX, runs a restoring shift-subtract division one quotient bit per cycle, and holds the pipeline through a stall request until the result is ready. The quotient and remainder are returned to EX, which writes them to LO and HI. It sits beside the ALU inside EX; its stall request feeds the pipeline stall controller.

## Interface
Parameters:
- DIV_CYCLES, 32: number of iteration cycles; equals the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a DIV/DIVU; EX drives it as is_div & ~ready
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1  in  32  dividend (rs)
- opdata2  in  32  divisor (rt)
- annul  in  1  abort the current operation (flush or exception)
- result_lo  out  32  quotient, registered
- result_hi  out  32  remainder, registered
- ready  out  1  result valid; high only in DONE
- stallreq  out  1  pipeline stall request to the stall controller

## Operation
- States are IDLE, BUSY and DONE.
- **IDLE**
  - If start=1 and opdata2≠0: latch |opdata1| and |opdata2| (absolute value only when signed_div=1). Latch neg_q = signed_div & (op1[31]^op2[31]) and neg_r = signed_div & op1[31]. Clear the 65-bit working register to {33'b0, |op1|} and the counter to 0, then go to BUSY.
  - If start=1 and opdata2=0: set result_lo=0 and result_hi=0, then go to DONE.
  - Otherwise stay in IDLE.
- **BUSY**
  - Each cycle, compute diff = work[63:31] − {1'b0,divisor}.
  - If diff ≥ 0: work ← {diff[31:0], work[30:0], 1}. Otherwise: work ← {work[63:0], 0}.
  - Increment the counter. When counter = DIV_CYCLES−1, go to DONE and load the results:
    - result_lo = neg_q ? −work_lo : work_lo
    - result_hi = neg_r ? −work_hi : work_hi
- **DONE**
  - ready=1.
  - If start=0, go to IDLE. If start=1, stay in DONE; the EX protocol makes this unreachable.
- **annul=1** in any state: next state is IDLE and the counter clears. Result registers are not updated. annul takes priority over start.
- **Arithmetic:**
  - The absolute value of 0x80000000 is 0x80000000, treated as unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- **Divide by zero:** the result is defined as lo=0, hi=0.
- result_lo and result_hi hold their value until the next division completes.

## Timing
- **Reset:** state=IDLE, counter=0, result_lo=0, result_hi=0, ready=0, stallreq=0.
- **stallreq:** combinational, start & (state≠DONE) & ~annul. It is high from the cycle start is first seen, including that first IDLE cycle.
- **Normal latency:** start sampled in IDLE at cycle t. BUSY occupies t+1..t+32. DONE at t+33, with ready=1 and stallreq=0. The pipeline advances at the t+33 edge.
- **Divide-by-zero latency:** start at t, DONE at t+1.
- **Back-to-back divisions:** the cycle after DONE, start=0 and the FSM returns to IDLE. A following DIV then arrives in IDLE and is accepted in that same cycle. There is no lost cycle beyond the DONE→IDLE return.
- **Outside stall:** when EX is frozen by an external stall, start stays high and the operands stay stable. The divider does not re-latch operands while in BUSY.
- **Annul timing:** annul at any edge gives IDLE on the next cycle, with stallreq dropping combinationally in the annul cycle. A start asserted in the cycle after annul begins a fresh division.
- **Reset mid-operation:** same effect as annul, and the result registers are cleared.

## Structure
- Shared defines header holds:
  - state encodings DIV_IDLE, DIV_BUSY, DIV_DONE (2-bit)
  - DivStart / DivStop
  - DIV_CYCLES
- One natural sub-module: div_step, combinational. It takes work[64:0] and divisor[31:0] and returns next work[64:0]. It contains the 33-bit subtract and the shift.
- The sign fix-up and the FSM stay in div_seq.

## Test plan
- **Unsigned basic:** DIVU 7 / 2 at t → stallreq high t..t+32; ready at t+33; lo=3, hi=1.
- **Signed mixed signs:** DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- **Signed overflow and unsigned extremes:**
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- **Divide by zero:** DIV 5 / 0 → ready at t+1; lo=0, hi=0; no BUSY cycles.
- **Annul:** annul asserted on the 10th BUSY cycle → IDLE next cycle; ready never rises; results keep their previous values. A new DIVU 100 / 7 then gives lo=14, hi=2 at +33.
- **Back-to-back and reset:**
  - Two consecutive DIVUs, 9/4 then 10/3 → first ready at t+33; second start accepted at t+34 (IDLE); second ready at t+67 with lo=3, hi=1.
  - rst on BUSY cycle 5 → all outputs 0 on the next cycle.
